// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// imm_gen_pipe : one-cycle pipelined RISC-V immediate generator with
//                valid/ready handshake, illegal-format flag and error counter.
//                Define IMM_GEN_SKID_EN for a one-entry skid buffer.
// Revision     : 1.0
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:7]      instr,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immext,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_FULL      = 2'd1
`ifdef IMM_GEN_SKID_EN
        , ST_FULL_SKID = 2'd2
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic              w_illegal;
    logic              w_accept;
    logic              w_xfer;
    logic              w_load_out;
    logic [XLEN-1:0]   r_immext;
    logic [TAG_W-1:0]  r_tag;
    logic              r_illegal;
    logic [7:0]        r_err;

    // Every format's top bit is either instr[31] or a zero, so one 32-bit
    // value sign-extended from its MSB covers both datapath widths.
    always_comb begin
        w_imm32   = '0;
        w_illegal = 1'b0;
        case (immsrc)
            3'b000: w_imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                               instr[11:8], 1'b0};
            3'b011: w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                               instr[30:21], 1'b0};
            3'b100: w_imm32 = {instr[31:12], 12'b0};
            3'b101: w_imm32 = {27'b0, instr[19:15]};
            3'b110: w_imm32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            default: w_illegal = 1'b1;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign w_imm = w_imm32;
        end
    endgenerate

    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = out_valid && out_ready;
    assign out_valid = (r_state != ST_EMPTY);

`ifdef IMM_GEN_SKID_EN
    logic              w_load_skid;
    logic              w_load_from_skid;
    logic              r_in_ready;
    logic [XLEN-1:0]   r_skid_imm;
    logic [TAG_W-1:0]  r_skid_tag;
    logic              r_skid_illegal;

    assign in_ready = r_in_ready;
`else
    logic              r_run;

    assign in_ready = r_run && (!out_valid || out_ready);
`endif

    always_comb begin
        w_state_next = r_state;
        w_load_out   = 1'b0;
`ifdef IMM_GEN_SKID_EN
        w_load_skid      = 1'b0;
        w_load_from_skid = 1'b0;
`endif
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_FULL;
                    w_load_out   = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    if (w_accept) w_load_out   = 1'b1;
                    else          w_state_next = ST_EMPTY;
                end
`ifdef IMM_GEN_SKID_EN
                else if (w_accept) begin
                    w_state_next = ST_FULL_SKID;
                    w_load_skid  = 1'b1;
                end
`endif
            end
`ifdef IMM_GEN_SKID_EN
            ST_FULL_SKID: begin
                if (w_xfer) begin
                    w_state_next     = ST_FULL;
                    w_load_from_skid = 1'b1;
                end
            end
`endif
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_immext  <= '0;
            r_tag     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load_out) begin
                r_immext  <= w_imm;
                r_tag     <= in_tag;
                r_illegal <= w_illegal;
            end
`ifdef IMM_GEN_SKID_EN
            else if (w_load_from_skid) begin
                r_immext  <= r_skid_imm;
                r_tag     <= r_skid_tag;
                r_illegal <= r_skid_illegal;
            end
`endif
        end
    end

`ifdef IMM_GEN_SKID_EN
    // in_ready tracks the next skid occupancy so it leaves the flop directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready     <= 1'b0;
            r_skid_imm     <= '0;
            r_skid_tag     <= '0;
            r_skid_illegal <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next != ST_FULL_SKID);
            if (w_load_skid) begin
                r_skid_imm     <= w_imm;
                r_skid_tag     <= in_tag;
                r_skid_illegal <= w_illegal;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 8'd0;
        end else if (w_accept && w_illegal && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
        end
    end

    assign immext      = r_immext;
    assign out_tag     = r_tag;
    assign out_illegal = r_illegal;
    assign err_count   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// tb_imm_gen_pipe : scoreboard bench driving an XLEN=32 and an XLEN=64
//                   imm_gen_pipe from the same handshake stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, out_ready;
    logic [31:7] instr;
    logic [2:0]  immsrc;
    logic [4:0]  in_tag;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] immext;
    logic [4:0]  out_tag;
    logic [7:0]  err_count;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] immext64;
    logic [4:0]  out_tag64;
    logic [7:0]  err_count64;

    logic [63:0] cur_e32, cur_e64;
    logic        busy;

    typedef struct {
        logic [63:0] e32;
        logic [63:0] e64;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .immext(immext),
        .out_tag(out_tag), .out_illegal(out_illegal), .err_count(err_count)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .immext(immext64),
        .out_tag(out_tag64), .out_illegal(out_illegal64), .err_count(err_count64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] i, input logic [2:0] s, input bit x64);
        logic [63:0] r;
        case (s)
            3'd0: r = {{52{i[31]}}, i[31:20]};
            3'd1: r = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd2: r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4: r = {{32{i[31]}}, i[31:12], 12'h000};
            3'd5: r = {59'd0, i[19:15]};
            3'd6: r = x64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
            default: r = 64'd0;
        endcase
        if (!x64) r = {32'd0, r[31:0]};
        return r;
    endfunction

    // Scoreboard: compare the head while valid, pop on transfer, push on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", out_valid, q.size() != 0);
            check("out_valid64", out_valid64, q.size() != 0);
            if (out_valid && q.size() != 0) begin
                check("immext32", immext, q[0].e32);
                check("immext64", immext64, q[0].e64);
                check("tag32", out_tag, q[0].tag);
                check("tag64", out_tag64, q[0].tag);
                check("illegal32", out_illegal, q[0].ill);
                check("illegal64", out_illegal64, q[0].ill);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready)
                q.push_back('{e32: cur_e32, e64: cur_e64, tag: in_tag, ill: (immsrc == 3'b111)});
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [2:0] s, input logic [4:0] t,
                         input logic [63:0] e32, input logic [63:0] e64);
        in_valid = 1'b1;
        instr    = ins[31:7];
        immsrc   = s;
        in_tag   = t;
        cur_e32  = e32;
        cur_e64  = e64;
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] s, input logic [4:0] t,
                        input logic [63:0] e32, input logic [63:0] e64);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        drive(ins, s, t, e32, e64);
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic sendm(input logic [31:0] ins, input logic [2:0] s, input logic [4:0] t);
        send(ins, s, t, model(ins, s, 1'b0), model(ins, s, 1'b1));
    endtask

    task automatic offer(input logic [31:0] ins, input logic [2:0] s, input logic [4:0] t);
        drive(ins, s, t, model(ins, s, 1'b0), model(ins, s, 1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", q.size(), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; immsrc = '0; in_tag = '0; cur_e32 = '0; cur_e64 = '0; busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_immext", immext, 0);
        check("rst_immext64", immext64, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_in_ready64", in_ready64, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("rel_in_ready_edge", in_ready, 1);
        check("rel_in_ready64_edge", in_ready64, 1);

        // Directed formats with hand-derived results
        out_ready = 1'b1;
        send(32'hFFF00093, 3'b000, 5'd1, 64'h00000000FFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        check("latency_valid", out_valid, 1);
        send(32'hFE000EE3, 3'b010, 5'd2, 64'h00000000FFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
        send(32'h123450B7, 3'b100, 5'd3, 64'h0000000012345000, 64'h0000000012345000);
        send(32'h8000006F, 3'b011, 5'd4, 64'h00000000FFF00000, 64'hFFFFFFFFFFF00000);
        send(32'h03F00000, 3'b110, 5'd5, 64'h000000000000001F, 64'h000000000000003F);
        send(32'h000F8073, 3'b101, 5'd6, 64'h000000000000001F, 64'h000000000000001F);
        drain();

        // Backpressure: four back-to-back requests, out_ready low for three edges
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 4; k++)
                    sendm(32'h00000093 | (32'(k) << 20), 3'b000, 5'(k));
            end
            begin
                @(negedge clk);
                check("bp_rdy_first", in_ready, 1);
                @(negedge clk);
`ifdef IMM_GEN_SKID_EN
                check("bp_rdy_after1", in_ready, 1);
`else
                check("bp_rdy_after1", in_ready, 0);
`endif
                @(negedge clk);
                check("bp_rdy_after2", in_ready, 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random legal formats under random backpressure
        busy = 1'b1;
        fork
            begin
                for (int k = 0; k < 40; k++)
                    sendm($urandom, 3'($urandom_range(0, 6)), 5'(k));
                busy = 1'b0;
            end
            begin
                int c;
                c = 0;
                while (busy && c < 3000) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                    c++;
                end
            end
        join
        drain();

        // Illegal format and counter saturation
        for (int k = 0; k < 300; k++) begin
            send($urandom, 3'b111, 5'(k), 64'd0, 64'd0);
            if (k == 99) begin
                check("err_count_100", err_count, 100);
                check("err_count64_100", err_count64, 100);
            end
        end
        check("err_count_sat", err_count, 255);
        check("err_count64_sat", err_count64, 255);
        drain();

        // Reset while the output stage is stalled (skid occupied when present)
        out_ready = 1'b0;
        offer(32'hABC00093, 3'b000, 5'd10);
        offer(32'h12300093, 3'b000, 5'd11);
`ifdef IMM_GEN_SKID_EN
        check("skid_full_in_ready", in_ready, 0);
`endif
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_valid64", out_valid64, 0);
        check("arst_err_count", err_count, 0);
        check("arst_immext", immext, 0);
        check("arst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_err_count", err_count, 0);
        sendm(32'h80000013, 3'b000, 5'd7);
        sendm(32'h00000013, 3'b111, 5'd8);
        check("post_rst_err_one", err_count, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
